// File: rtl/fetch_pkg.sv
//------------------------------------------------------------------------------
// Module      : fetch_pkg
// Description : Shared types and constants for the instruction-fetch queue.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fetch_pkg;

    localparam int          c_ADDR_W   = 32;
    localparam int          c_INSTR_W  = 32;
    localparam int          c_PC_STEP  = 4;
    localparam logic [31:0] c_RESET_PC = 32'h0000_0000;

    typedef struct packed {
        logic [c_ADDR_W-1:0]  pc;
        logic [c_INSTR_W-1:0] instr;
    } fq_entry_t;

endpackage

`default_nettype wire

// File: rtl/fq_storage.sv
//------------------------------------------------------------------------------
// Module      : fq_storage
// Description : Entry register array, one synchronous write, one async read.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fq_storage
    import fetch_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fq_entry_t,
    parameter int  PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             i_wr_en,
    input  logic [PTR_W-1:0] i_wr_addr,
    input  T                 i_wr_data,
    input  logic [PTR_W-1:0] i_rd_addr,
    output T                 o_rd_data
);

    // Contents are intentionally not reset; occupancy lives in the control logic.
    T r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

`default_nettype wire

// File: rtl/fetch_queue.sv
//------------------------------------------------------------------------------
// Module      : fetch_queue
// Description : PC generator plus DEPTH-entry prefetch FIFO feeding decode.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = c_ADDR_W,
    parameter int                INSTR_W  = c_INSTR_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(c_RESET_PC),
    parameter int                PC_STEP  = c_PC_STEP
) (
    input  logic                       Clk,
    input  logic                       Reset,
    output logic [ADDR_W-1:0]          IM_Addr,
    output logic                       IM_Req,
    input  logic [INSTR_W-1:0]         IM_Data,
    input  logic                       Redirect,
    input  logic [ADDR_W-1:0]          RedirectPC,
    output logic                       Out_Valid,
    input  logic                       Out_Ready,
    output logic [INSTR_W-1:0]         Out_Instr,
    output logic [ADDR_W-1:0]          Out_PC,
    output logic [ADDR_W-1:0]          Out_NextPC,
    output logic [$clog2(DEPTH+1)-1:0] Count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = $clog2(DEPTH+1);

    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [ADDR_W-1:0]  c_STEP     = ADDR_W'(PC_STEP);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    logic [ADDR_W-1:0]  r_pc;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic   w_pop;
    logic   w_push;
    entry_t w_wr_entry;
    entry_t w_head;

    // A redirect masks both handshake directions so the stale head is dropped, not consumed.
    assign Out_Valid = (r_count != '0) & ~Redirect;
    assign w_pop     = Out_Valid & Out_Ready;
    assign w_push    = ~Redirect & ((r_count != c_FULL) | w_pop);

    assign IM_Req     = w_push;
    assign IM_Addr    = r_pc;
    assign Count      = r_count;
    assign Out_Instr  = w_head.instr;
    assign Out_PC     = w_head.pc;
    assign Out_NextPC = w_head.pc + c_STEP;

    assign w_wr_entry.pc    = r_pc;
    assign w_wr_entry.instr = IM_Data;

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            r_pc     <= RESET_PC;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (Redirect) begin
            r_pc     <= RedirectPC;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
                r_pc     <= r_pc + c_STEP;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + c_CNT_ONE;
            end else if (!w_push && w_pop) begin
                r_count <= r_count - c_CNT_ONE;
            end
        end
    end

    fq_storage #(
        .DEPTH (DEPTH),
        .T     (entry_t),
        .PTR_W (c_PTR_W)
    ) u_storage (
        .clk       (Clk),
        .i_wr_en   (w_push),
        .i_wr_addr (r_wr_ptr),
        .i_wr_data (w_wr_entry),
        .i_rd_addr (r_rd_ptr),
        .o_rd_data (w_head)
    );

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
//------------------------------------------------------------------------------
// Module      : tb_fetch_queue
// Description : Self-checking bench for fetch_queue against a queue-based model.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_fetch_queue;

    logic        Clk = 1'b0;
    logic        Reset = 1'b0;
    logic        Redirect = 1'b0;
    logic [31:0] RedirectPC = 32'h0;
    logic        Out_Ready = 1'b0;
    logic [31:0] IM_Addr;
    logic        IM_Req;
    logic [31:0] IM_Data;
    logic        Out_Valid;
    logic [31:0] Out_Instr;
    logic [31:0] Out_PC;
    logic [31:0] Out_NextPC;
    logic [2:0]  Count;

    // Second instance for the address-wrap case.
    logic        rst_w = 1'b0;
    logic        redir_w = 1'b0;
    logic [31:0] redir_pc_w = 32'h0;
    logic        rdy_w = 1'b0;
    logic [31:0] im_addr_w;
    logic        im_req_w;
    logic [31:0] im_data_w;
    logic        valid_w;
    logic [31:0] instr_w;
    logic [31:0] pc_w;
    logic [31:0] next_pc_w;
    logic [2:0]  count_w;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t        q[$];
    logic [31:0] mpc;

    always #5 Clk = ~Clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    assign IM_Data   = memf(IM_Addr);
    assign im_data_w = memf(im_addr_w);

    fetch_queue u_dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .IM_Addr    (IM_Addr),
        .IM_Req     (IM_Req),
        .IM_Data    (IM_Data),
        .Redirect   (Redirect),
        .RedirectPC (RedirectPC),
        .Out_Valid  (Out_Valid),
        .Out_Ready  (Out_Ready),
        .Out_Instr  (Out_Instr),
        .Out_PC     (Out_PC),
        .Out_NextPC (Out_NextPC),
        .Count      (Count)
    );

    fetch_queue #(.RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
        .Clk        (Clk),
        .Reset      (rst_w),
        .IM_Addr    (im_addr_w),
        .IM_Req     (im_req_w),
        .IM_Data    (im_data_w),
        .Redirect   (redir_w),
        .RedirectPC (redir_pc_w),
        .Out_Valid  (valid_w),
        .Out_Ready  (rdy_w),
        .Out_Instr  (instr_w),
        .Out_PC     (pc_w),
        .Out_NextPC (next_pc_w),
        .Count      (count_w)
    );

    // Reference: the queue holds fetched {pc, instr} in program order, at most 4 deep.
    function automatic logic [132:0] exp_vec();
        logic v, p, r;
        ent_t h;
        h.pc = 32'h0;
        h.instr = 32'h0;
        v = (q.size() != 0) && !Redirect;
        p = v && Out_Ready;
        r = !Redirect && ((q.size() < 4) || p);
        if (v) h = q[0];
        return {v, 3'(q.size()), r, mpc, h.pc, h.instr, v ? h.pc + 32'd4 : 32'h0};
    endfunction

    function automatic logic [132:0] obs_vec();
        return {Out_Valid, Count, IM_Req, IM_Addr,
                Out_Valid ? Out_PC : 32'h0,
                Out_Valid ? Out_Instr : 32'h0,
                Out_Valid ? Out_NextPC : 32'h0};
    endfunction

    task automatic model_edge();
        logic v, p, r;
        ent_t e;
        v = (q.size() != 0) && !Redirect;
        p = v && Out_Ready;
        r = !Redirect && ((q.size() < 4) || p);
        if (Redirect) begin
            q.delete();
            mpc = RedirectPC;
        end else begin
            if (p) void'(q.pop_front());
            if (r) begin
                e.pc = mpc;
                e.instr = memf(mpc);
                q.push_back(e);
                mpc = mpc + 32'd4;
            end
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        Redirect = 1'b0;
        Out_Ready = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Reset = 1'b1;
        q.delete();
        mpc = 32'h0;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        Redirect = 1'b0;
        Out_Ready = 1'b1;
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        n_vec++;
        if (Count !== 3'd0) begin
            n_err++;
            $display("FAIL reset_count got %0d want 0", Count);
        end
        n_vec++;
        if (Out_Valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_valid got %b want 0", Out_Valid);
        end
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        q.delete();
        mpc = 32'h0;
        @(negedge Clk);
        n_vec++;
        if (obs_vec() !== exp_vec()) begin
            n_err++;
            $display("FAIL reset_release got %h want %h", obs_vec(), exp_vec());
        end
        tick();
    endtask

    task automatic test_stream();
        Out_Ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge Clk);
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL stream cyc %0d got %h want %h", i, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_stall();
        do_reset();
        Out_Ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL stall cyc %0d got %h want %h", i, obs_vec(), exp_vec());
            end
            if (i == 5) begin
                n_vec++;
                if (IM_Addr !== 32'h10 || IM_Req !== 1'b0 || Count !== 3'd4) begin
                    n_err++;
                    $display("FAIL stall_sat got addr=%h req=%b cnt=%0d want 10/0/4",
                             IM_Addr, IM_Req, Count);
                end
            end
            tick();
        end
        Out_Ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge Clk);
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL stall_release cyc %0d got %h want %h", i, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        do_reset();
        Out_Ready = 1'b0;
        repeat (3) begin
            @(negedge Clk);
            tick();
        end
        Redirect = 1'b1;
        RedirectPC = 32'h40;
        Out_Ready = 1'b1;
        @(negedge Clk);
        n_vec++;
        if (obs_vec() !== exp_vec() || Out_Valid !== 1'b0) begin
            n_err++;
            $display("FAIL redirect_cycle got %h want %h", obs_vec(), exp_vec());
        end
        tick();
        Redirect = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge Clk);
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL redirect_after cyc %0d got %h want %h", i, obs_vec(), exp_vec());
            end
            if (i == 1) begin
                n_vec++;
                if (Out_Valid !== 1'b1 || Out_PC !== 32'h40) begin
                    n_err++;
                    $display("FAIL redirect_first got v=%b pc=%h want 1/00000040", Out_Valid, Out_PC);
                end
            end
            tick();
        end
    endtask

    task automatic test_full_wrap();
        do_reset();
        Out_Ready = 1'b0;
        repeat (5) begin
            @(negedge Clk);
            tick();
        end
        Out_Ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge Clk);
            n_vec++;
            if (obs_vec() !== exp_vec() || Count !== 3'd4 || IM_Req !== 1'b1) begin
                n_err++;
                $display("FAIL full_wrap cyc %0d got %h want %h", i, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        Out_Ready = 1'b0;
        repeat (2) begin
            @(negedge Clk);
            tick();
        end
        n_vec++;
        if (Count !== 3'd2) begin
            n_err++;
            $display("FAIL async_pre got cnt=%0d want 2", Count);
        end
        #2;
        Reset = 1'b0;
        #1;
        n_vec++;
        if (Out_Valid !== 1'b0 || Count !== 3'd0 || IM_Addr !== 32'h0) begin
            n_err++;
            $display("FAIL async_reset got v=%b cnt=%0d addr=%h want 0/0/0", Out_Valid, Count, IM_Addr);
        end
        q.delete();
        mpc = 32'h0;
        @(posedge Clk);
        #1;
        Reset = 1'b1;
        Out_Ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge Clk);
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL async_after cyc %0d got %h want %h", i, obs_vec(), exp_vec());
            end
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 400; i++) begin
            Out_Ready = ($urandom_range(0, 3) != 0);
            Redirect = ($urandom_range(0, 15) == 0);
            RedirectPC = $urandom();
            @(negedge Clk);
            n_vec++;
            if (obs_vec() !== exp_vec()) begin
                n_err++;
                $display("FAIL random cyc %0d got %h want %h", i, obs_vec(), exp_vec());
            end
            tick();
        end
        Redirect = 1'b0;
    endtask

    task automatic test_pc_wrap();
        logic [31:0] seq [4];
        int k;
        seq[0] = 32'hFFFF_FFF8;
        seq[1] = 32'hFFFF_FFFC;
        seq[2] = 32'h0000_0000;
        seq[3] = 32'h0000_0004;
        k = 0;
        rdy_w = 1'b1;
        rst_w = 1'b1;
        for (int c = 0; c < 10 && k < 4; c++) begin
            @(negedge Clk);
            if (valid_w) begin
                n_vec++;
                if (pc_w !== seq[k] || instr_w !== memf(seq[k]) || next_pc_w !== seq[k] + 32'd4) begin
                    n_err++;
                    $display("FAIL pc_wrap idx %0d got pc=%h instr=%h next=%h want pc=%h",
                             k, pc_w, instr_w, next_pc_w, seq[k]);
                end
                k++;
            end
            @(posedge Clk);
            #1;
        end
        if (k < 4) begin
            n_vec++;
            n_err++;
            $display("FAIL pc_wrap_timeout got %0d entries want 4", k);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        @(posedge Clk);
        #1;
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_full_wrap();
        test_async_reset();
        test_random();
        test_pc_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
